digit_sequencer: RTL and testbench
==================================

// Module: digit_sequencer
// PURPOSE
//  Converts a binary value (0..9999) to four BCD display digits by driving the
//  divide10 iterative divider once per digit: value/10 -> units, quotient/10 ->
//  tens, and so on. Sits between the value source and the 7-segment scan driver.
//  Also produces a leading-zero blank mask and overflow/error flags.
// PARAMETERS
//  VALUE_W   14   width of value input and div_value (divide10 dividend width)
//  Q_W       10   width of div_quotient from divide10
//  DIGITS    4    number of BCD digits produced (MAX = 10**DIGITS-1 = 9999)
//  TIMEOUT   64   cycles to wait for div_ready before aborting with err
// PORTS
//  clk           in   1          system clock, rising edge
//  rst           in   1          asynchronous, active-high reset
//  start         in   1          1-cycle pulse: convert value; ignored while busy
//  value         in   VALUE_W    binary input, sampled on accepted start
//  div_start     out  1          1-cycle pulse to divide10 start
//  div_value     out  VALUE_W    dividend to divide10, stable while busy
//  div_quotient  in   Q_W        divide10 quotient
//  div_remainder in   4          divide10 remainder (0..9)
//  div_ready     in   1          divide10 result-valid level
//  digits        out  4*DIGITS   BCD, [3:0]=units ... [15:12]=thousands
//  blank         out  DIGITS     1 = digit is a leading zero (bit0 = units, never 1)
//  busy          out  1          conversion in progress
//  done          out  1          1-cycle pulse when digits/blank/flags updated
//  overflow      out  1          last accepted value > 9999
//  err           out  1          last conversion aborted on timeout
// BEHAVIOUR
//  Reset: state IDLE; digits=0, blank=4'b1110, div_value=0, all 1-bit outs 0.
//  States: IDLE -> CHECK -> ISSUE -> ARM -> WAIT -> STORE -> (ISSUE | DONE) -> IDLE.
//  IDLE: start=1 latches value into work reg, clears digit index k=0, busy=1.
//  CHECK: value > 9999 -> overflow=1, digits=16'hFFFF, blank=0, go DONE;
//   no div_start is ever issued. Else overflow=0, div_value=work, go ISSUE.
//  ISSUE: div_start=1 for exactly this cycle; timeout counter cleared.
//  ARM: one cycle; div_ready ignored (stale result from previous divide).
//  WAIT: div_ready=1 -> STORE. Counter reaches TIMEOUT -> err=1, digits and blank
//   keep previous values, go DONE.
//  STORE: digit k <= div_remainder; work <= zero-extended div_quotient;
//   div_value updated same edge. k==DIGITS-1 -> DONE, else k++ and ISSUE.
//  Per-digit latency ISSUE..STORE = 3 + divider latency; done follows final STORE
//   by exactly one cycle.
//  DONE: done=1 one cycle; blank computed from new digits: digit i blanked iff it
//   and all higher digits are 0, i>0. busy drops same cycle as done=1 -> IDLE.
//  digits/blank update atomically in DONE only; display never sees partial values.
//  err cleared on next accepted start; overflow rewritten in each CHECK.
//  start during busy (incl. DONE cycle) ignored, not queued.
//  rst mid-conversion: immediate return to reset values; div_start never glitches.
//  value = 0 -> digits 0000, blank 1110 (units always shown).
// TESTING
//  start, value=1024 -> 4 div_start pulses, div_value 1024,102,10,1; digits=16'h1024, blank=0000, done x1
//  value=7 -> digits=16'h0007, blank=1110; value=0 -> digits=0000, blank=1110
//  value=12000 -> no div_start, overflow=1, digits=16'hFFFF, done 2 cycles after start
//  div_ready held 0 -> err=1 after 64 WAIT cycles, digits unchanged from prior run
//  start pulsed again mid-conversion of 9999 -> ignored, result 16'h9999 exactly once
//  rst asserted during WAIT of 2nd digit -> busy=0, digits=0, blank=1110 at once

Source files
------------

// File: rtl/digit_sequencer.sv
// digit_sequencer
// Converts a binary value (0..10**DIGITS-1) into DIGITS BCD digits. It runs an
// external iterative divide-by-10 unit once per digit: the remainder of each
// divide becomes the next digit (units first) and the quotient becomes the next
// dividend. The result also carries a leading-zero blank mask for the 7-segment
// scan driver, an overflow flag for out-of-range inputs, and an err flag for a
// divider that never answers.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start, value   1-cycle request and the binary value to convert
//   div_start      1-cycle pulse telling the divider to begin
//   div_value      dividend for the divider, held stable while busy
//   div_quotient   divider quotient
//   div_remainder  divider remainder (0..9)
//   div_ready      divider result-valid level
//   digits         BCD result, [3:0] = units
//   blank          leading-zero mask, bit0 (units) is never blanked
//   busy           conversion in progress
//   done           1-cycle pulse when digits/blank/flags have been updated
//   overflow       last accepted value was out of range
//   err            last conversion was abandoned on a divider timeout
module digit_sequencer #(
    parameter int VALUE_W = 14,
    parameter int Q_W     = 10,
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  div_start,
    output logic [VALUE_W-1:0]    div_value,
    input  logic [Q_W-1:0]        div_quotient,
    input  logic [3:0]            div_remainder,
    input  logic                  div_ready,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err
);

    localparam int K_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int T_W     = $clog2(TIMEOUT + 1);
    localparam int MAX_VAL = 10**DIGITS - 1;

    localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t               state;
    logic [VALUE_W-1:0]   work;
    logic [K_W-1:0]       k;
    logic [4*DIGITS-1:0]  stage;
    logic [T_W-1:0]       timer;

    // A digit is blanked when it and every digit above it are zero. The
    // units digit is excluded so that a value of zero still shows "0".
    function automatic logic [DIGITS-1:0] leading_blank(input logic [4*DIGITS-1:0] d);
        logic              all_zero;
        logic [DIGITS-1:0] b;
        all_zero = 1'b1;
        b        = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (d[4*i +: 4] == 4'd0);
            b[i]     = all_zero;
        end
        return b;
    endfunction

    // Sequencer. Digits are collected in a private staging register and only
    // copied to the visible outputs on the transition into S_DONE, so the
    // display never sees a half-converted number. div_start and done default
    // low every cycle, so each can be high for only the single cycle spent in
    // S_ISSUE or S_DONE.
    // The divider may still present ready from the previous divide while it
    // takes in the new start, so S_ARM lets one cycle pass before S_WAIT looks
    // at div_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            work      <= '0;
            k         <= '0;
            stage     <= '0;
            timer     <= '0;
            div_start <= 1'b0;
            div_value <= '0;
            digits    <= '0;
            blank     <= BLANK_ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            div_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work  <= value;
                        k     <= '0;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (work > VALUE_W'(MAX_VAL)) begin
                        overflow <= 1'b1;
                        digits   <= '1;
                        blank    <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        overflow  <= 1'b0;
                        div_value <= work;
                        div_start <= 1'b1;
                        timer     <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_ARM;
                end
                S_ARM: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_ready) begin
                        stage[int'(k)*4 +: 4] <= div_remainder;
                        work                  <= VALUE_W'(div_quotient);
                        div_value             <= VALUE_W'(div_quotient);
                        state                 <= S_STORE;
                    end else if (timer == T_W'(TIMEOUT - 1)) begin
                        // Abandon: the visible digits and blank keep the last good result.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STORE: begin
                    if (k == K_W'(DIGITS - 1)) begin
                        digits <= stage;
                        blank  <= leading_blank(stage);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        k         <= k + 1'b1;
                        div_start <= 1'b1;
                        timer     <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here; a request in
                    // the done cycle is dropped rather than queued.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_sequencer.sv
// tb_digit_sequencer
// Drives digit_sequencer with directed and random values. A behavioural
// divide-by-10 unit with a programmable latency, plus a "stuck" mode, stands
// in for the real divider. Expected digits, blank masks, flags and dividend
// sequences are computed arithmetically from the value itself.
module tb_digit_sequencer;

    localparam int VALUE_W = 14;
    localparam int Q_W     = 10;
    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [VALUE_W-1:0] value;
    logic               div_start;
    logic [VALUE_W-1:0] div_value;
    logic [Q_W-1:0]     div_quotient;
    logic [3:0]         div_remainder;
    logic               div_ready;
    logic [15:0]        digits;
    logic [3:0]         blank;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               err;

    int checks = 0;
    int errors = 0;

    digit_sequencer #(
        .VALUE_W(VALUE_W),
        .Q_W(Q_W),
        .DIGITS(DIGITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .value(value),
        .div_start(div_start),
        .div_value(div_value),
        .div_quotient(div_quotient),
        .div_remainder(div_remainder),
        .div_ready(div_ready),
        .digits(digits),
        .blank(blank),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural divider: keeps the previous result (and ready) visible for one
    // cycle after a start, then drops ready until div_lat cycles later.
    int                 div_lat   = 1;
    bit                 div_stuck = 1'b0;
    int                 div_cnt;
    logic [VALUE_W-1:0] div_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ready     <= 1'b0;
            div_cnt       <= 0;
            div_op        <= '0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_stuck) begin
            div_ready <= 1'b0;
            div_cnt   <= 0;
        end else if (div_start) begin
            div_op  <= div_value;
            div_cnt <= div_lat + 1;
        end else if (div_cnt > 1) begin
            div_cnt   <= div_cnt - 1;
            div_ready <= 1'b0;
        end else if (div_cnt == 1) begin
            div_ready     <= 1'b1;
            div_quotient  <= Q_W'(int'(div_op) / 10);
            div_remainder <= 4'(int'(div_op) % 10);
            div_cnt       <= 0;
        end
    end

    logic [VALUE_W-1:0] issued[$];
    int                 done_count;
    int                 run_cycles;
    logic [15:0]        prev_digits;
    logic [3:0]         prev_blank;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] modelDigits(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10**i)) % 10);
        return r;
    endfunction

    function automatic logic [3:0] modelBlank(input int v);
        int         nsig;
        int         t;
        logic [3:0] b;
        if (v > 9999) return 4'b0000;
        nsig = 1;
        t    = v / 10;
        while (t > 0) begin
            nsig++;
            t = t / 10;
        end
        for (int i = 0; i < DIGITS; i++) b[i] = (i >= nsig);
        return b;
    endfunction

    // One conversion: pulse start, optionally pulse a second start at cycle
    // restart_at (busy, so it must be ignored), wait for done, then spend one
    // more cycle (optionally pulsing start during the done cycle) and confirm
    // the block went idle without starting again.
    task automatic applyStimulus(input int v, input int lat, input bit stuck,
                                 input int restart_at, input bit poke_done);
        bit seen;
        issued.delete();
        done_count = 0;
        div_lat    = lat;
        div_stuck  = stuck;
        @(negedge clk);
        start = 1'b1;
        value = VALUE_W'(v);
        run_cycles = 0;
        seen = 1'b0;
        while (!seen && run_cycles < 300) begin
            @(negedge clk);
            run_cycles++;
            start = 1'b0;
            if (run_cycles == restart_at) begin
                start = 1'b1;
                value = 14'd1234;
            end
            if (run_cycles == 1) checkOutput("busy_after_start", 32'(busy), 32'd1);
            if (div_start) issued.push_back(div_value);
            if (done) begin
                done_count++;
                seen = 1'b1;
            end
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        start = poke_done;
        value = 14'd1;
        @(negedge clk);
        start = 1'b0;
        if (done) done_count++;
        checkOutput("idle_after_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        checkOutput("no_restart", 32'(busy), 32'd0);
        div_stuck = 1'b0;
    endtask

    task automatic runConversion(input int v, input int lat, input int restart_at, input bit poke_done);
        logic [15:0] exp_d;
        logic [3:0]  exp_b;
        exp_d = modelDigits(v);
        exp_b = modelBlank(v);
        applyStimulus(v, lat, 1'b0, restart_at, poke_done);
        checkOutput($sformatf("digits_%0d", v), 32'(digits), 32'(exp_d));
        checkOutput($sformatf("blank_%0d", v), 32'(blank), 32'(exp_b));
        checkOutput($sformatf("overflow_%0d", v), 32'(overflow), 32'(v > 9999));
        checkOutput($sformatf("err_%0d", v), 32'(err), 32'd0);
        checkOutput($sformatf("done_count_%0d", v), 32'(done_count), 32'd1);
        if (v > 9999) begin
            checkOutput("overflow_no_div_start", 32'(issued.size()), 32'd0);
            checkOutput("overflow_latency", 32'(run_cycles), 32'd2);
        end else begin
            checkOutput($sformatf("div_starts_%0d", v), 32'(issued.size()), 32'(DIGITS));
            for (int i = 0; i < DIGITS && i < issued.size(); i++)
                checkOutput($sformatf("div_value_%0d_%0d", v, i), 32'(issued[i]), 32'(v / (10**i)));
        end
        prev_digits = exp_d;
        prev_blank  = exp_b;
    endtask

    initial begin
        int v;
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_digits", 32'(digits), 32'd0);
        checkOutput("reset_blank", 32'(blank), 32'b1110);
        checkOutput("reset_flags", {27'd0, busy, done, overflow, err, div_start}, 32'd0);
        checkOutput("reset_div_value", 32'(div_value), 32'd0);
        rst = 1'b0;
        prev_digits = '0;
        prev_blank  = 4'b1110;

        runConversion(1024, 2, 0, 1'b0);
        runConversion(7, 1, 0, 1'b0);
        runConversion(0, 3, 0, 1'b0);
        runConversion(12000, 1, 0, 1'b0);
        runConversion(9999, 2, 5, 1'b1);

        // Divider never answers: abort after TIMEOUT wait cycles, keep old digits.
        applyStimulus(4321, 1, 1'b1, 0, 1'b0);
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_overflow", 32'(overflow), 32'd0);
        checkOutput("timeout_digits_kept", 32'(digits), 32'(prev_digits));
        checkOutput("timeout_blank_kept", 32'(blank), 32'(prev_blank));
        checkOutput("timeout_done_count", 32'(done_count), 32'd1);
        checkOutput("timeout_latency", 32'(run_cycles), 32'(4 + TIMEOUT));
        checkOutput("timeout_div_starts", 32'(issued.size()), 32'd1);

        runConversion(10000, 1, 0, 1'b0);
        runConversion(9999, 1, 0, 1'b0);
        runConversion(50, 4, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 7) == 0) v = int'($urandom_range(10000, 16383));
            else v = int'($urandom_range(0, 9999));
            runConversion(v, int'($urandom_range(1, 4)), 0, 1'b0);
        end

        // Reset while waiting on the second digit's divide.
        issued.delete();
        div_lat = 6;
        @(negedge clk);
        start = 1'b1;
        value = 14'd5678;
        guard = 0;
        while (issued.size() < 2 && guard < 100) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (div_start) issued.push_back(div_value);
        end
        checkOutput("reset_test_reached_digit2", 32'(issued.size()), 32'd2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_digits", 32'(digits), 32'd0);
        checkOutput("midrst_blank", 32'(blank), 32'b1110);
        checkOutput("midrst_pulses", {30'd0, div_start, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runConversion(4096, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
